// File: rtl/onehot_decoder_scan_if.sv
// Control/observe bundle for onehot_decoder_scan.
// The master drives the i_* controls; the slave returns the registered o_* outputs.
interface onehot_decoder_scan_if #(
    parameter int unsigned N_SEL = 4
);
    localparam int unsigned OUT_W = 2 ** N_SEL;

    logic             i_en;
    logic             i_mode;
    logic             i_in_valid;
    logic [N_SEL-1:0] i_in;
    logic [N_SEL-1:0] i_scan_last;
    logic [OUT_W-1:0] o_out;
    logic [N_SEL-1:0] o_code;
    logic             o_wrap;

    modport master (
        output i_en, i_mode, i_in_valid, i_in, i_scan_last,
        input  o_out, o_code, o_wrap
    );

    modport slave (
        input  i_en, i_mode, i_in_valid, i_in, i_scan_last,
        output o_out, o_code, o_wrap
    );
endinterface

// File: rtl/onehot_decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable, latched direct decode and an
// auto-scan mode that walks codes 0..scan_last, holding each code for DWELL clocks.
module onehot_decoder_scan #(
    parameter int unsigned N_SEL      = 4,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    onehot_decoder_scan_if.slave bus
);
    localparam int unsigned     OUT_W    = 2 ** N_SEL;
    localparam int unsigned     CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_t;

    state_t           r_state, w_state_d;
    logic [N_SEL-1:0] r_code, w_code_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_wrap, w_wrap_d;
    logic [OUT_W-1:0] r_out, w_out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_code  <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            r_out   <= {OUT_W{ACTIVE_LOW}};
        end else begin
            r_state <= w_state_d;
            r_code  <= w_code_d;
            r_cnt   <= w_cnt_d;
            r_wrap  <= w_wrap_d;
            r_out   <= w_out_d;
        end
    end

    always_comb begin
        w_state_d = StIdle;
        w_code_d  = r_code;
        w_cnt_d   = r_cnt;
        w_wrap_d  = 1'b0;
        w_out_d   = '0;

        if (bus.i_en) begin
            w_state_d = bus.i_mode ? StScan : StDirect;
        end

        unique case (w_state_d)
            StDirect: begin
                if (bus.i_in_valid) begin
                    w_code_d = bus.i_in;
                end
            end
            StScan: begin
                if (r_state != StScan) begin
                    w_code_d = '0;
                    w_cnt_d  = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_d = '0;
                    // >= so a scan_last lowered below the current code wraps on the next step
                    if (r_code >= bus.i_scan_last) begin
                        w_code_d = '0;
                        w_wrap_d = 1'b1;
                    end else begin
                        w_code_d = r_code + 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase

        if (w_state_d != StIdle) begin
            w_out_d = OUT_W'(1) << w_code_d;
        end
        w_out_d = w_out_d ^ {OUT_W{ACTIVE_LOW}};
    end

    assign bus.o_out  = r_out;
    assign bus.o_code = r_code;
    assign bus.o_wrap = r_wrap;
endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Randomised and directed checks of onehot_decoder_scan against a behavioural model;
// two instances cover N_SEL=4/DWELL=2 active-high and N_SEL=3/DWELL=3 active-low.
module tb_onehot_decoder_scan;
    logic       clk = 1'b0;
    logic       rst;
    logic       en, mode, in_valid;
    logic [3:0] in_c, last;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: 0 idle, 1 direct, 2 scan; held = cycles current code shown
    int m_state[2];
    int m_code[2];
    int m_held[2];
    int m_wrap[2];

    logic [15:0] seq3[9] = '{16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0004,
                             16'h0004, 16'h0008, 16'h0008, 16'h0001};

    onehot_decoder_scan_if #(.N_SEL(4)) bus0 ();
    onehot_decoder_scan_if #(.N_SEL(3)) bus1 ();

    assign bus0.i_en        = en;
    assign bus0.i_mode      = mode;
    assign bus0.i_in_valid  = in_valid;
    assign bus0.i_in        = in_c;
    assign bus0.i_scan_last = last;
    assign bus1.i_en        = en;
    assign bus1.i_mode      = mode;
    assign bus1.i_in_valid  = in_valid;
    assign bus1.i_in        = in_c[2:0];
    assign bus1.i_scan_last = last[2:0];

    onehot_decoder_scan #(.N_SEL(4), .DWELL(2), .ACTIVE_LOW(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    onehot_decoder_scan #(.N_SEL(3), .DWELL(3), .ACTIVE_LOW(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0;
            m_code[d]  = 0;
            m_held[d]  = 0;
            m_wrap[d]  = 0;
        end
    endtask

    task automatic model_step(input int d);
        int lim, dwell, vin, vlast, ns;
        lim   = (d == 0) ? 15 : 7;
        dwell = (d == 0) ? 2 : 3;
        vin   = int'(in_c) & lim;
        vlast = int'(last) & lim;
        ns    = !en ? 0 : (mode ? 2 : 1);
        m_wrap[d] = 0;
        if (ns == 1 && in_valid) begin
            m_code[d] = vin;
        end else if (ns == 2) begin
            if (m_state[d] != 2) begin
                m_code[d] = 0;
                m_held[d] = 1;
            end else if (m_held[d] >= dwell) begin
                m_held[d] = 1;
                if (m_code[d] >= vlast) begin
                    m_code[d] = 0;
                    m_wrap[d] = 1;
                end else begin
                    m_code[d] = m_code[d] + 1;
                end
            end else begin
                m_held[d] = m_held[d] + 1;
            end
        end
        m_state[d] = ns;
    endtask

    function automatic logic [31:0] exp_out(input int d);
        logic [31:0] v, mask;
        mask = (d == 0) ? 32'h0000_FFFF : 32'h0000_00FF;
        v    = (m_state[d] == 0) ? 32'd0 : (32'd1 << m_code[d]);
        if (d == 1) v = ~v & mask;
        return v;
    endfunction

    task automatic check_dut();
        check_eq("out0", 32'(bus0.o_out), exp_out(0));
        check_eq("code0", 32'(bus0.o_code), 32'(m_code[0]));
        check_eq("wrap0", 32'(bus0.o_wrap), 32'(m_wrap[0]));
        check_eq("out1", 32'(bus1.o_out), exp_out(1));
        check_eq("code1", 32'(bus1.o_code), 32'(m_code[1]));
        check_eq("wrap1", 32'(bus1.o_wrap), 32'(m_wrap[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
        #1;
        check_dut();
    endtask

    // Reset pulse placed between clock edges
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_dut();
        check_eq("arst_out0", 32'(bus0.o_out), 32'h0000);
        check_eq("arst_out1", 32'(bus1.o_out), 32'h00FF);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_c     = '0;
        last     = '0;
        #1;
        model_reset();
        check_dut();
        check_eq("rst_out1", 32'(bus1.o_out), 32'h00FF);
        repeat (2) cycle();
        rst = 1'b0;

        // Direct decode, latency one clock, hold without in_valid
        en = 1'b1; mode = 1'b0; in_c = 4'hA; in_valid = 1'b1;
        cycle();
        check_eq("t2_out", 32'(bus0.o_out), 32'h0400);
        check_eq("t2_code", 32'(bus0.o_code), 32'hA);
        in_c = 4'h3; in_valid = 1'b0;
        cycle();
        check_eq("t2_hold", 32'(bus0.o_out), 32'h0400);

        // Enable drop mid-direct
        in_c = 4'h7; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; en = 1'b0;
        cycle();
        check_eq("t5_off", 32'(bus0.o_out), 32'h0000);
        check_eq("t5_code", 32'(bus0.o_code), 32'h7);
        en = 1'b1;
        cycle();
        check_eq("t5_back", 32'(bus0.o_out), 32'h0080);

        // Active-low instance
        in_c = 4'h2; in_valid = 1'b1;
        cycle();
        check_eq("t6_out1", 32'(bus1.o_out), 32'h00FB);
        in_valid = 1'b0;

        // Scan from idle with scan_last=3
        en = 1'b0;
        cycle();
        en = 1'b1; mode = 1'b1; last = 4'd3;
        for (int i = 0; i < 9; i++) begin
            cycle();
            check_eq("t3_out", 32'(bus0.o_out), 32'(seq3[i]));
            check_eq("t3_wrap", 32'(bus0.o_wrap), (i == 8) ? 32'd1 : 32'd0);
        end
        cycle();
        async_reset();
        check_eq("t1_code0", 32'(bus0.o_code), 32'd0);
        check_eq("t1_wrap0", 32'(bus0.o_wrap), 32'd0);

        // Lowering scan_last below the current code
        last = 4'd9;
        for (int i = 0; i < 40 && bus0.o_code != 4'd5; i++) cycle();
        check_eq("t4_reach", 32'(bus0.o_code), 32'd5);
        last = 4'd2;
        cycle();
        cycle();
        check_eq("t4_code", 32'(bus0.o_code), 32'd0);
        check_eq("t4_wrap", 32'(bus0.o_wrap), 32'd1);
        repeat (12) cycle();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            in_valid = $urandom_range(0, 1) == 1;
            in_c     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) last = 4'($urandom_range(0, 15));
            cycle();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
